// File: rtl/perf_cntr_ctrl_if.sv
// Data-bus port of the performance-counter block: decoded select, word
// read/write strobes and the registered read-response pair.
interface perf_cntr_ctrl_if #(
    parameter int unsigned BASE_OFFS_W = 6
) ();
    logic                   sel_i;
    logic [BASE_OFFS_W-1:0] addr_i;
    logic                   we_i;
    logic [31:0]            wdata_i;
    logic                   re_i;
    logic [31:0]            rdata_o;
    logic                   rvalid_o;

    modport master (
        output sel_i, addr_i, we_i, wdata_i, re_i,
        input  rdata_o, rvalid_o
    );

    modport slave (
        input  sel_i, addr_i, we_i, wdata_i, re_i,
        output rdata_o, rvalid_o
    );
endinterface

// File: rtl/perf_cntr_ctrl.sv
// Performance counters (cycle, instret, br_pred, br_misp) with RUN/CLEAR/SNAP
// control, sticky wrap flags and an atomic snapshot read over MMIO.
module perf_cntr_ctrl #(
    parameter int unsigned BASE_OFFS_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            halt_i,
    input  logic            stall_i,
    input  logic            instret_i,
    input  logic            br_pred_i,
    input  logic            br_misp_i,
    perf_cntr_ctrl_if.slave bus
);
    logic [63:0]            r_cyc;
    logic [63:0]            r_inst;
    logic [63:0]            r_pred;
    logic [63:0]            r_misp;
    logic [63:0]            r_snap [4];
    logic [3:0]             r_wrap;
    logic                   r_snap_vld;
    logic                   r_run;

    logic [63:0]            w_cnt [4];
    logic [3:0]             w_inc;
    logic                   w_act;
    logic                   w_rd;
    logic                   w_ctrl_wr;
    logic                   w_clear;
    logic                   w_snap;
    logic [BASE_OFFS_W-3:0] w_widx;
    logic [31:0]            w_rdata;
    logic                   w_unused;

    assign w_act     = r_run & ~halt_i;
    assign w_rd      = bus.sel_i & bus.re_i;
    assign w_widx    = bus.addr_i[BASE_OFFS_W-1:2];
    assign w_ctrl_wr = bus.sel_i & bus.we_i & (w_widx == '0);
    assign w_clear   = w_ctrl_wr & bus.wdata_i[1];
    assign w_snap    = w_ctrl_wr & bus.wdata_i[2];
    assign w_unused  = ^{bus.wdata_i[31:3], bus.addr_i[1:0]};

    always_comb begin
        w_inc[0] = w_act;
        w_inc[1] = w_act & ~stall_i & instret_i;
        w_inc[2] = w_act & ~stall_i & br_pred_i;
        w_inc[3] = w_act & ~stall_i & br_pred_i & br_misp_i;
        w_cnt[0] = r_cyc;
        w_cnt[1] = r_inst;
        w_cnt[2] = r_pred;
        w_cnt[3] = r_misp;
    end

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_cyc  <= '0;
            r_inst <= '0;
            r_pred <= '0;
            r_misp <= '0;
        end else begin
            if (w_inc[0]) r_cyc  <= r_cyc  + 64'd1;
            if (w_inc[1]) r_inst <= r_inst + 64'd1;
            if (w_inc[2]) r_pred <= r_pred + 64'd1;
            if (w_inc[3]) r_misp <= r_misp + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_wrap <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_inc[i] && (w_cnt[i] == '1)) r_wrap[i] <= 1'b1;
            end
        end
    end

    // Snapshot takes the pre-edge live values, so CLEAR+SNAP keeps the old counts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 4; i++) r_snap[i] <= '0;
        end else if (w_snap) begin
            for (int unsigned i = 0; i < 4; i++) r_snap[i] <= w_cnt[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_snap_vld <= 1'b0;
            r_run      <= 1'b1;
        end else begin
            if (w_snap) begin
                r_snap_vld <= 1'b1;
            end else if (w_clear) begin
                r_snap_vld <= 1'b0;
            end
            if (w_ctrl_wr) r_run <= bus.wdata_i[0];
        end
    end

    always_comb begin
        w_rdata = '0;
        case (int'(w_widx))
            0:       w_rdata = {31'd0, r_run};
            1:       w_rdata = {27'd0, r_snap_vld, r_wrap};
            2:       w_rdata = r_snap[0][31:0];
            3:       w_rdata = r_snap[0][63:32];
            4:       w_rdata = r_snap[1][31:0];
            5:       w_rdata = r_snap[1][63:32];
            6:       w_rdata = r_snap[2][31:0];
            7:       w_rdata = r_snap[2][63:32];
            8:       w_rdata = r_snap[3][31:0];
            9:       w_rdata = r_snap[3][63:32];
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.rdata_o  <= '0;
            bus.rvalid_o <= 1'b0;
        end else begin
            bus.rvalid_o <= w_rd;
            if (w_rd) bus.rdata_o <= w_rdata;
        end
    end
endmodule

// File: tb/tb_perf_cntr_ctrl.sv
// Directed bench for perf_cntr_ctrl: reads push expected words into a queue,
// a negedge monitor pops and compares on every rvalid_o pulse.
module tb_perf_cntr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic halt = 1'b0;
    logic stall = 1'b0;
    logic instret = 1'b0;
    logic br_pred = 1'b0;
    logic br_misp = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q [$];
    string       nm_q  [$];

    perf_cntr_ctrl_if #(.BASE_OFFS_W(6)) bus ();

    perf_cntr_ctrl #(.BASE_OFFS_W(6)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .halt_i    (halt),
        .stall_i   (stall),
        .instret_i (instret),
        .br_pred_i (br_pred),
        .br_misp_i (br_misp),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rvalid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rdata 0x%08h, expected no response", bus.rdata_o);
            end else begin
                check(nm_q.pop_front(), bus.rdata_o, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        bus.sel_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.wdata_i = d;
        tick();
        bus.sel_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string nm);
        bus.sel_i = 1'b1; bus.re_i = 1'b1; bus.addr_i = a;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        tick();
        bus.sel_i = 1'b0; bus.re_i = 1'b0;
    endtask

    // Each row: {stall, br_pred, br_misp}; six counted predictions, two counted mispredictions.
    logic [2:0] br_vec [10] = '{3'b010, 3'b000, 3'b011, 3'b000, 3'b001,
                                3'b010, 3'b011, 3'b111, 3'b010, 3'b010};

    initial begin
        bus.sel_i = 1'b0; bus.we_i = 1'b0; bus.re_i = 1'b0;
        bus.addr_i = '0; bus.wdata_i = '0;

        // Reset, then 11 counting edges (two of them reads) before the SNAP edge.
        tick(); tick();
        rst = 1'b0;
        check("reset_rdata", bus.rdata_o, 32'd0);
        check("reset_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        rd(6'h04, 32'h0000_0000, "reset_status");
        rd(6'h00, 32'h0000_0001, "reset_ctrl_run");
        repeat (9) tick();
        wr(6'h00, 32'h5);
        rd(6'h08, 32'd11, "idle_cyc_lo");
        rd(6'h0C, 32'd0,  "idle_cyc_hi");
        rd(6'h04, 32'h10, "idle_status_snapvld");

        // instret for 20 cycles, stalled on 5 of them
        wr(6'h00, 32'h3);
        for (int i = 0; i < 20; i++) begin
            instret = 1'b1;
            stall = (i == 3 || i == 7 || i == 8 || i == 12 || i == 19);
            tick();
        end
        instret = 1'b0; stall = 1'b0;
        wr(6'h00, 32'h5);
        rd(6'h10, 32'd15, "instret_lo");
        rd(6'h14, 32'd0,  "instret_hi");
        rd(6'h08, 32'd20, "instret_cyc_lo");

        // halt freezes cycle and instret
        wr(6'h00, 32'h3);
        halt = 1'b1; instret = 1'b1;
        repeat (8) tick();
        halt = 1'b0; instret = 1'b0;
        wr(6'h00, 32'h5);
        rd(6'h08, 32'd0, "halt_cyc_lo");
        rd(6'h10, 32'd0, "halt_instret_lo");

        // branch prediction / misprediction gating
        wr(6'h00, 32'h3);
        for (int i = 0; i < 10; i++) begin
            logic [2:0] v;
            v = br_vec[i];
            stall = v[2]; br_pred = v[1]; br_misp = v[0];
            tick();
        end
        stall = 1'b0; br_pred = 1'b0; br_misp = 1'b0;
        wr(6'h00, 32'h5);
        rd(6'h18, 32'd6, "br_pred_lo");
        rd(6'h1C, 32'd0, "br_pred_hi");
        rd(6'h20, 32'd2, "br_misp_lo");
        rd(6'h24, 32'd0, "br_misp_hi");

        // cycle wrap: FFFE -> FFFF -> 0 (wrap) -> 1, then SNAP
        wr(6'h00, 32'h3);
        force dut.r_cyc = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.r_cyc;
        repeat (3) tick();
        wr(6'h00, 32'h5);
        rd(6'h08, 32'd1,  "wrap_cyc_lo");
        rd(6'h0C, 32'd0,  "wrap_cyc_hi");
        rd(6'h04, 32'h11, "wrap_status");
        wr(6'h00, 32'h3);
        rd(6'h04, 32'h00, "clear_status");
        wr(6'h00, 32'h5);
        rd(6'h08, 32'd1,  "clear_cyc_restart");

        // RUN+CLEAR+SNAP together
        wr(6'h00, 32'h3);
        instret = 1'b1;
        repeat (5) tick();
        instret = 1'b0;
        wr(6'h00, 32'h7);
        rd(6'h08, 32'd5,  "csnap_cyc_old");
        rd(6'h10, 32'd5,  "csnap_inst_old");
        rd(6'h04, 32'h10, "csnap_status");
        wr(6'h00, 32'h5);
        rd(6'h08, 32'd3,  "csnap_cyc_restart");
        rd(6'h10, 32'd0,  "csnap_inst_zero");
        rd(6'h00, 32'h1,  "csnap_ctrl_run");

        // back-to-back reads, unmapped offset, then rvalid drops
        rd(6'h04, 32'h10, "b2b_status");
        rd(6'h30, 32'h0,  "b2b_unmapped");
        tick();
        check("rvalid_drop", {31'd0, bus.rvalid_o}, 32'd0);

        wr(6'h08, 32'hDEAD_BEEF);
        rd(6'h08, 32'd3, "snap_write_ignored");

        // read and write CTRL in the same cycle returns the pre-write value
        bus.sel_i = 1'b1; bus.we_i = 1'b1; bus.re_i = 1'b1;
        bus.addr_i = 6'h00; bus.wdata_i = 32'h0;
        exp_q.push_back(32'h1); nm_q.push_back("rdwr_prewrite");
        tick();
        bus.sel_i = 1'b0; bus.we_i = 1'b0; bus.re_i = 1'b0;

        // RUN=0 stops counting; strobes without sel are ignored
        wr(6'h00, 32'h2);
        repeat (4) tick();
        bus.we_i = 1'b1; bus.re_i = 1'b1; bus.addr_i = 6'h00; bus.wdata_i = 32'h3;
        tick();
        bus.we_i = 1'b0; bus.re_i = 1'b0;
        wr(6'h00, 32'h4);
        rd(6'h08, 32'd0,  "stopped_cyc_lo");
        rd(6'h00, 32'h0,  "nosel_run_kept");
        rd(6'h04, 32'h10, "pre_reset_status");

        // reset coincident with a read
        rst = 1'b1;
        bus.sel_i = 1'b1; bus.re_i = 1'b1; bus.addr_i = 6'h04;
        tick();
        bus.sel_i = 1'b0; bus.re_i = 1'b0;
        check("rst_read_rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        check("rst_read_rdata", bus.rdata_o, 32'd0);
        rst = 1'b0;
        rd(6'h00, 32'h1, "post_reset_ctrl");
        rd(6'h04, 32'h0, "post_reset_status");

        tick(); tick();
        check("responses_outstanding", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units, expected completion");
        $fatal(1);
    end
endmodule
